clock_time_ctrl: RTL and testbench
==================================

Name: clock_time_ctrl

Overview:
- Sequencing and time-set controller for the multi-function digital clock.
- Converts the 1 Hz tick into per-digit count enables for the cascaded digit counters: seconds units mod-10, seconds tens mod-6, minutes units mod-10, minutes tens mod-6, hours mod-24.
- Owns the user time-set state machine (mode/increment keys, auto-exit timeout, display blink).

Parameters:
- TIMEOUT_S, 10, number of tick_1hz pulses without any key press before set mode auto-exits to normal; range 1..255.
- BLINK_DIV, 25000000, clk cycles per blink phase toggle; range ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-clk-wide pulse, once per second.
- key_mode  input  1  debounced one-clk pulse; advances set mode.
- key_inc  input  1  debounced one-clk pulse; increments the selected field.
- co_sec_lo  input  1  seconds-units counter at 9 (combinational carry).
- co_sec_hi  input  1  seconds-tens counter at 5.
- co_min_lo  input  1  minutes-units counter at 9.
- co_min_hi  input  1  minutes-tens counter at 5.
- en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr  output  1 each  count enables; combinational.
- clr_sec  output  1  registered one-clk pulse; synchronously clears both seconds counters.
- mode  output  2  registered: 0 = NORMAL, 1 = SET_HOUR, 2 = SET_MIN.
- blink_hr, blink_min  output  1 each  registered; 1 = blank that field this phase.

Behaviour:
- Reset (rst=1 at clk edge): state NORMAL, mode=0, clr_sec=0, blink_hr=0, blink_min=0, timeout count=0, blink divider=0, blink phase=0. All en_* are 0 during reset regardless of inputs.
- NORMAL (ripple chain, zero latency, all terms gated by tick_1hz):
  - en_sec_lo = tick_1hz.
  - en_sec_hi = tick_1hz & co_sec_lo.
  - en_min_lo = tick_1hz & co_sec_lo & co_sec_hi.
  - en_min_hi = en_min_lo & co_min_lo.
  - en_hr = en_min_lo & co_min_lo & co_min_hi.
  - The hour counter wraps 23→00 internally.
- SET_HOUR:
  - tick_1hz does not advance the time; all seconds/minutes enables are 0.
  - en_hr = key_inc & ~key_mode.
- SET_MIN:
  - en_min_lo = key_inc & ~key_mode; en_min_hi = en_min_lo & co_min_lo.
  - en_hr = 0; minutes wrap 59→00 with no hour carry.
- Transitions (registered; outputs follow state one cycle after the key pulse):
  - NORMAL --key_mode--> SET_HOUR.
  - SET_HOUR --key_mode--> SET_MIN.
  - SET_MIN --key_mode--> NORMAL.
  - SET_HOUR or SET_MIN --timeout--> NORMAL.
- clr_sec: asserted for exactly the one cycle after the NORMAL→SET_HOUR transition, so seconds restart at 00 on exit.
- Simultaneous key_mode and key_inc: key_mode wins; the increment is dropped (no en_*).
- A tick_1hz arriving in the same cycle as the key_mode that exits SET_MIN is ignored; that second is lost by design.
- Timeout:
  - An 8-bit count clears on any key pulse and on entry to a set state.
  - It increments on tick_1hz while in a set state.
  - When the count equals TIMEOUT_S-1 and tick_1hz=1, the next state is NORMAL and the count clears.
  - In NORMAL the count is held at 0.
- Blink:
  - The divider counts 0..BLINK_DIV-1 continuously; at wrap the blink phase toggles.
  - blink_hr = (state==SET_HOUR) & phase; blink_min = (state==SET_MIN) & phase.
  - On entry to a set state the divider and phase clear, so the field is visible first.
- Reset mid-set: return to NORMAL next cycle; time-counter contents are untouched (this block holds none).

Test Plan:
- Reset, then 3 ticks with all co_*=0 → en_sec_lo pulses 3 times, one clk each; all other en_* stay 0; mode=0.
- NORMAL, tick_1hz with co_sec_lo=co_sec_hi=co_min_lo=co_min_hi=1 → en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr all 1 in that same cycle (59:59 → hour carry).
- key_mode once → next cycle mode=1 and clr_sec=1 for exactly 1 clk. Then 5 key_inc pulses → 5 en_hr pulses. Ticks with co_sec_lo=1 → en_sec_lo=en_sec_hi=0.
- key_mode twice → mode=2. key_inc with co_min_lo=1, co_min_hi=1 → en_min_lo=en_min_hi=1, en_hr=0. key_mode+key_inc in the same cycle → no en_*, mode=0 next cycle.
- TIMEOUT_S=3: enter SET_HOUR, give 3 ticks and no keys → mode=0 the cycle after the 3rd tick. A key_inc after tick 2 restarts the count, so exit comes 3 ticks after that key.
- BLINK_DIV=4 in SET_MIN → blink_min=0 for 4 clks after entry, then 1 for 4 clks, alternating; blink_hr stays 0. rst=1 mid-sequence → mode=0 and both blink outputs 0 next cycle.

Source files
------------

// File: rtl/clock_time_ctrl_if.sv
// Signal bundle between the digital-clock controller and its surroundings
// (tick source, key debouncers, cascaded digit counters, display driver).
//   master : environment side. Drives tick/keys/carries, observes enables,
//            mode and blink.
//   slave  : controller side (clock_time_ctrl).
// Signals:
//   tick_1hz                        one-clk pulse per second
//   key_mode, key_inc               debounced one-clk key pulses
//   co_sec_lo/co_sec_hi             seconds units at 9 / seconds tens at 5
//   co_min_lo/co_min_hi             minutes units at 9 / minutes tens at 5
//   en_sec_lo..en_hr                per-digit count enables (combinational)
//   clr_sec                         one-clk clear for both seconds counters
//   mode                            0 NORMAL, 1 SET_HOUR, 2 SET_MIN
//   blink_hr, blink_min             1 = blank that field this phase
interface clock_time_ctrl_if;
  logic       tick_1hz;
  logic       key_mode;
  logic       key_inc;
  logic       co_sec_lo;
  logic       co_sec_hi;
  logic       co_min_lo;
  logic       co_min_hi;
  logic       en_sec_lo;
  logic       en_sec_hi;
  logic       en_min_lo;
  logic       en_min_hi;
  logic       en_hr;
  logic       clr_sec;
  logic [1:0] mode;
  logic       blink_hr;
  logic       blink_min;

  modport master (
    output tick_1hz, key_mode, key_inc,
    output co_sec_lo, co_sec_hi, co_min_lo, co_min_hi,
    input  en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr,
    input  clr_sec, mode, blink_hr, blink_min
  );

  modport slave (
    input  tick_1hz, key_mode, key_inc,
    input  co_sec_lo, co_sec_hi, co_min_lo, co_min_hi,
    output en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr,
    output clr_sec, mode, blink_hr, blink_min
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Sequencing and time-set controller for the multi-function digital clock.
// Turns the 1 Hz tick into ripple count enables for the digit counters
// (ss units/tens, mm units/tens, hours) and runs the user time-set FSM
// with key-driven field increments, auto-exit timeout and field blinking.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - clock_time_ctrl_if.slave (tick, keys, carries in; enables,
//          clr_sec, mode, blink out)
// Parameters:
//   TIMEOUT_S - ticks without a key press before set mode exits (1..255)
//   BLINK_DIV - clk cycles per blink phase (>= 2)
module clock_time_ctrl #(
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  clock_time_ctrl_if.slave    bus
);

  localparam int unsigned DIV_W = $clog2(BLINK_DIV);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT_S - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       to_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             phase;
  logic             clr_q;
  logic             blink_hr_q;
  logic             blink_min_q;

  logic div_wrap;
  logic phase_n;
  logic to_hit;
  logic inc;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign phase_n  = div_wrap ? ~phase : phase;
  assign to_hit   = bus.tick_1hz && (to_cnt == TO_LAST);
  // key_mode wins over a simultaneous key_inc: the increment is dropped.
  assign inc      = bus.key_inc & ~bus.key_mode;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= NORMAL;
      to_cnt      <= '0;
      div_cnt     <= '0;
      phase       <= 1'b0;
      clr_q       <= 1'b0;
      blink_hr_q  <= 1'b0;
      blink_min_q <= 1'b0;
    end else begin
      clr_q       <= 1'b0;
      blink_hr_q  <= 1'b0;
      blink_min_q <= 1'b0;
      // Free-running blink divider; restarted below on every set-state entry
      // so the selected field is visible first.
      div_cnt     <= div_wrap ? '0 : div_cnt + 1'b1;
      phase       <= phase_n;

      case (state)
        NORMAL: begin
          to_cnt <= '0;
          if (bus.key_mode) begin
            state   <= SET_HOUR;
            clr_q   <= 1'b1;
            div_cnt <= '0;
            phase   <= 1'b0;
          end
        end

        SET_HOUR: begin
          if (bus.key_mode) begin
            state   <= SET_MIN;
            to_cnt  <= '0;
            div_cnt <= '0;
            phase   <= 1'b0;
          end else if (to_hit && !bus.key_inc) begin
            state  <= NORMAL;
            to_cnt <= '0;
          end else begin
            // A key press restarts the idle count.
            if (bus.key_inc)       to_cnt <= '0;
            else if (bus.tick_1hz) to_cnt <= to_cnt + 8'd1;
            blink_hr_q <= phase_n;
          end
        end

        SET_MIN: begin
          if (bus.key_mode) begin
            state  <= NORMAL;
            to_cnt <= '0;
          end else if (to_hit && !bus.key_inc) begin
            state  <= NORMAL;
            to_cnt <= '0;
          end else begin
            if (bus.key_inc)       to_cnt <= '0;
            else if (bus.tick_1hz) to_cnt <= to_cnt + 8'd1;
            blink_min_q <= phase_n;
          end
        end

        default: begin
          state  <= NORMAL;
          to_cnt <= '0;
        end
      endcase
    end
  end

  logic en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr;

  // NOTE: every output gets a default before the case so no latch is inferred
  // for the combinations a branch does not assign.
  always_comb begin
    en_sec_lo = 1'b0;
    en_sec_hi = 1'b0;
    en_min_lo = 1'b0;
    en_min_hi = 1'b0;
    en_hr     = 1'b0;
    if (!rst) begin
      case (state)
        NORMAL: begin
          // Zero-latency ripple: each stage enabled when all lower digits carry.
          en_sec_lo = bus.tick_1hz;
          en_sec_hi = bus.tick_1hz & bus.co_sec_lo;
          en_min_lo = bus.tick_1hz & bus.co_sec_lo & bus.co_sec_hi;
          en_min_hi = en_min_lo & bus.co_min_lo;
          en_hr     = en_min_lo & bus.co_min_lo & bus.co_min_hi;
        end
        SET_HOUR: en_hr = inc;
        SET_MIN: begin
          // Minutes wrap 59->00 without carrying into the hours.
          en_min_lo = inc;
          en_min_hi = inc & bus.co_min_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.en_sec_lo = en_sec_lo;
  assign bus.en_sec_hi = en_sec_hi;
  assign bus.en_min_lo = en_min_lo;
  assign bus.en_min_hi = en_min_hi;
  assign bus.en_hr     = en_hr;
  assign bus.clr_sec   = clr_q;
  assign bus.mode      = state;
  assign bus.blink_hr  = blink_hr_q;
  assign bus.blink_min = blink_min_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed-vector bench for clock_time_ctrl (TIMEOUT_S=3, BLINK_DIV=4).
// The stimulus task drives one vector per clock just after the rising edge
// and pushes the hand-computed expected outputs for that cycle; a monitor
// pops and compares on the falling edge.
module tb_clock_time_ctrl;

  logic clk;
  logic rst;

  clock_time_ctrl_if bus ();

  clock_time_ctrl #(
    .TIMEOUT_S (3),
    .BLINK_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // en bit order: {sec_lo, sec_hi, min_lo, min_hi, hr}
  typedef struct packed {
    logic [4:0] en;
    logic       clr;
    logic [1:0] mode;
    logic       cb;   // compare blink outputs in this cycle
    logic       bh;
    logic       bm;
  } exp_t;

  exp_t sb_q[$];
  int   idx_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_no   = 0;

  // co order: {sec_lo, sec_hi, min_lo, min_hi}
  task automatic v(input logic r, input logic t, input logic km,
                   input logic ki, input logic [3:0] co,
                   input logic [4:0] en, input logic clr,
                   input logic [1:0] md, input logic cb,
                   input logic bh, input logic bm);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    bus.tick_1hz = t;
    bus.key_mode = km;
    bus.key_inc  = ki;
    {bus.co_sec_lo, bus.co_sec_hi, bus.co_min_lo, bus.co_min_hi} = co;
    e.en   = en;
    e.clr  = clr;
    e.mode = md;
    e.cb   = cb;
    e.bh   = bh;
    e.bm   = bm;
    sb_q.push_back(e);
    idx_q.push_back(vec_no);
    vec_no++;
  endtask

  // Monitor
  initial begin : monitor
    exp_t       e;
    int         id;
    logic [4:0] act_en;
    logic       ok;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        id = idx_q.pop_front();
        act_en = {bus.en_sec_lo, bus.en_sec_hi, bus.en_min_lo,
                  bus.en_min_hi, bus.en_hr};
        ok = (act_en === e.en) && (bus.clr_sec === e.clr) &&
             (bus.mode === e.mode) &&
             (!e.cb || ((bus.blink_hr === e.bh) && (bus.blink_min === e.bm)));
        n_checks++;
        if (ok) n_pass++;
        else
          $display("FAIL vec%0d: got en=%b clr=%b mode=%0d blink_hr/min=%b%b, want en=%b clr=%b mode=%0d blink_hr/min=%b%b (blink %s)",
                   id, act_en, bus.clr_sec, bus.mode, bus.blink_hr,
                   bus.blink_min, e.en, e.clr, e.mode, e.bh, e.bm,
                   e.cb ? "checked" : "ignored");
      end
    end
  end

  initial begin : stimulus
    rst          = 1'b1;
    bus.tick_1hz = 1'b0;
    bus.key_mode = 1'b0;
    bus.key_inc  = 1'b0;
    bus.co_sec_lo = 1'b0;
    bus.co_sec_hi = 1'b0;
    bus.co_min_lo = 1'b0;
    bus.co_min_hi = 1'b0;

    // Reset: enables forced low even with a full carry chain / keys
    v(1, 1, 0, 0, 4'b1111, 5'b00000, 0, 2'd0, 1, 0, 0);
    v(1, 0, 1, 1, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);

    // NORMAL: three plain ticks
    v(0, 1, 0, 0, 4'b0000, 5'b10000, 0, 2'd0, 1, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b10000, 0, 2'd0, 1, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b10000, 0, 2'd0, 1, 0, 0);

    // NORMAL: carry chain patterns (59:59 full carry first)
    v(0, 1, 0, 0, 4'b1111, 5'b11111, 0, 2'd0, 1, 0, 0);
    v(0, 1, 0, 0, 4'b1000, 5'b11000, 0, 2'd0, 1, 0, 0);
    v(0, 1, 0, 0, 4'b1100, 5'b11100, 0, 2'd0, 1, 0, 0);
    v(0, 1, 0, 0, 4'b1110, 5'b11110, 0, 2'd0, 1, 0, 0);
    v(0, 0, 0, 0, 4'b1111, 5'b00000, 0, 2'd0, 1, 0, 0);

    // Enter SET_HOUR: clr_sec for one clock, 5 hour increments
    v(0, 0, 1, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 1, 2'd1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      v(0, 0, 0, 1, 4'b0000, 5'b00001, 0, 2'd1, 0, 0, 0);
      if (i < 4) v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    end
    // Ticks do not advance time in SET_HOUR (two ticks, below the timeout)
    v(0, 1, 0, 0, 4'b1111, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 1, 0, 0, 4'b1000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 0, 1, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);

    // SET_MIN: minute increments, no hour carry; mode+inc together
    v(0, 0, 0, 1, 4'b0011, 5'b00110, 0, 2'd2, 0, 0, 0);
    v(0, 0, 0, 1, 4'b0000, 5'b00100, 0, 2'd2, 0, 0, 0);
    v(0, 0, 0, 1, 4'b0010, 5'b00110, 0, 2'd2, 0, 0, 0);
    v(0, 1, 1, 1, 4'b1111, 5'b00000, 0, 2'd2, 0, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);

    // Timeout: exit the cycle after the 3rd tick
    v(0, 0, 1, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b00000, 1, 2'd1, 0, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);

    // Timeout restart: key_inc after tick 2, exit 3 ticks later
    v(0, 0, 1, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b00000, 1, 2'd1, 0, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 0, 0, 1, 4'b0000, 5'b00001, 0, 2'd1, 0, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b00000, 0, 2'd1, 0, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);

    // Blink in SET_MIN: 4 visible, 4 blank, 4 visible, then blank
    v(0, 0, 1, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);
    v(0, 0, 1, 0, 4'b0000, 5'b00000, 1, 2'd1, 1, 0, 0);
    for (int i = 0; i < 4; i++) v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd2, 1, 0, 0);
    for (int i = 0; i < 4; i++) v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd2, 1, 0, 1);
    for (int i = 0; i < 4; i++) v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd2, 1, 0, 0);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd2, 1, 0, 1);

    // Reset mid-set: enables low during reset, NORMAL and no blink next cycle
    v(1, 1, 0, 1, 4'b1111, 5'b00000, 0, 2'd2, 1, 0, 1);
    v(0, 0, 0, 0, 4'b0000, 5'b00000, 0, 2'd0, 1, 0, 0);
    v(0, 1, 0, 0, 4'b0000, 5'b10000, 0, 2'd0, 1, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, want 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
